instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter AW, default 8, SHALL set the instruction address and PC width.
REQ-002 Parameter DW, default 16, SHALL set the instruction word width; ir[7:0] is the opcode and ir[15:8] is the operand.
REQ-003 Parameter END_OPCODE, default 8'd30, SHALL set the opcode value that halts fetching.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port fetch_req, input, 1: the control state machine requests the next instruction.
REQ-007 Port jump_en, input, 1: PC redirect strobe.
REQ-008 Port jump_addr, input, AW: the redirect target.
REQ-009 Port imem_rd, output, 1: instruction memory read strobe.
REQ-010 Port imem_addr, output, AW: instruction memory address.
REQ-011 Port imem_rdata, input, DW: synchronous memory data, valid one cycle after imem_rd.
REQ-012 Port ir, output, DW: the instruction register delivered to the control state machine.
REQ-013 Port ir_valid, output, 1: ir holds a freshly fetched instruction.
REQ-014 Port pc, output, AW: the address of the next instruction to fetch.
REQ-015 Port halt, output, 1: the END instruction has been fetched.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, WAIT, HOLD and HALT.
REQ-017 In IDLE or HOLD, fetch_req=1 SHALL move the FSM to REQ and clear ir_valid on the next edge.
REQ-018 In REQ, the unit SHALL drive imem_rd=1 and imem_addr=pc, then go to WAIT.
REQ-019 In WAIT, the unit SHALL load ir<=imem_rdata and pc<=pc+1, then go to HOLD with ir_valid=1.
REQ-020 Without prefetch, latency SHALL be 3 cycles: fetch_req sampled at edge N gives ir_valid=1 after edge N+3.
REQ-021 The unit SHALL ignore fetch_req while the FSM is in REQ or WAIT.
REQ-022 ir SHALL stay stable from load until the next load.
REQ-023 pc SHALL wrap from 2^AW-1 to 0 with no flag.
REQ-024 jump_en=1 SHALL set pc<=jump_addr in any non-HALT state.
REQ-025 If jump_en=1 in REQ or WAIT, the in-flight data SHALL be discarded, ir SHALL be left unchanged, and the FSM SHALL go to IDLE.
REQ-026 If jump_en and fetch_req are both 1 in IDLE or HOLD, the jump SHALL apply first and the fetch SHALL read jump_addr.
REQ-027 A loaded opcode equal to END_OPCODE SHALL move the FSM to HALT with halt=1 and ir_valid=1 held.
REQ-028 In HALT, the unit SHALL ignore fetch_req and jump_en until reset.
REQ-029 imem_rd SHALL be 0 in every state except REQ (and during background prefetch, see REQ-034).

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, pc=0, ir=0, ir_valid=0, halt=0, imem_rd=0, imem_addr=0, with no clock required.
REQ-031 Reset asserted during REQ or WAIT SHALL abort the fetch, and no ir load SHALL follow reset release.
REQ-032 After reset release, the first fetch_req SHALL fetch address 0.

Configuration
REQ-033 Macro IFU_PREFETCH_EN SHALL compile in a one-entry prefetch buffer (valid bit, address tag, data).
REQ-034 With IFU_PREFETCH_EN, in HOLD with the buffer empty, the unit SHALL read pc in the background and fill the buffer.
REQ-035 With IFU_PREFETCH_EN, fetch_req with a buffer hit (tag==pc) SHALL load ir from the buffer and give ir_valid=1 after edge N+1.
REQ-036 With IFU_PREFETCH_EN, jump_en SHALL invalidate the buffer.
REQ-037 Without IFU_PREFETCH_EN, the buffer logic SHALL be absent and behaviour SHALL be exactly REQ-016 to REQ-029.

Structure
REQ-038 A shared package ifu_pkg SHALL hold the opcode constants (END=30, NOP=29, LOAD=5, STOR=13, JPNZ=16, ADD=23, SUB=25, MUL=27), the FSM state enum and the default AW/DW.
REQ-039 The prefetch buffer SHALL be a sub-module, ifu_prefetch_buf, instantiated only under IFU_PREFETCH_EN.

Verification
REQ-040 Reset, then memory[0]=16'h0505, then a fetch_req pulse SHALL give imem_rd with addr 0 one cycle later, ir=16'h0505 with ir_valid=1 three cycles after the request, and pc=1.
REQ-041 jump_en with jump_addr=8'h10 in HOLD, then fetch_req, SHALL give imem_addr=8'h10 and then pc=8'h11.
REQ-042 jump_en with jump_addr=8'h20 during WAIT SHALL leave ir unchanged, give pc=8'h20 and state=IDLE, with ir_valid staying 0.
REQ-043 Fetching memory[5]=16'h031E (opcode 30) SHALL give halt=1, and a later fetch_req SHALL produce no imem_rd.
REQ-044 pc=8'hFF and a fetch SHALL read address 8'hFF and then give pc=8'h00.
REQ-045 With IFU_PREFETCH_EN and sequential memory[0..3], back-to-back fetch_req SHALL give ir_valid one cycle after each request, and a jump SHALL cause a miss with 3-cycle latency.

Source files
------------

// File: rtl/ifu_pkg.sv
// +----------------------------------------------------------------------------
// | Module   : ifu_pkg
// | Purpose  : Shared opcodes, fetch FSM state encoding and default widths.
// | Revision : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package ifu_pkg;

  localparam int C_AW = 8;
  localparam int C_DW = 16;

  localparam logic [7:0] C_OP_END  = 8'd30;
  localparam logic [7:0] C_OP_NOP  = 8'd29;
  localparam logic [7:0] C_OP_LOAD = 8'd5;
  localparam logic [7:0] C_OP_STOR = 8'd13;
  localparam logic [7:0] C_OP_JPNZ = 8'd16;
  localparam logic [7:0] C_OP_ADD  = 8'd23;
  localparam logic [7:0] C_OP_SUB  = 8'd25;
  localparam logic [7:0] C_OP_MUL  = 8'd27;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } ifu_state_t;

endpackage

`default_nettype wire

// File: rtl/ifu_prefetch_buf.sv
// +----------------------------------------------------------------------------
// | Module   : ifu_prefetch_buf
// | Purpose  : One-entry instruction prefetch buffer (valid, address tag, data).
// | Revision : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module ifu_prefetch_buf
  import ifu_pkg::*;
#(
  parameter int AW = C_AW,
  parameter int DW = C_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_fill,
  input  logic [AW-1:0] i_fill_tag,
  input  logic [DW-1:0] i_fill_data,
  input  logic          i_inval,
  input  logic [AW-1:0] i_lookup_addr,
  output logic          o_valid,
  output logic          o_hit,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [AW-1:0] r_tag;
  logic [DW-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_inval) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_tag;
      r_data  <= i_fill_data;
    end
  end

  assign o_valid = r_valid;
  assign o_hit   = r_valid && (r_tag == i_lookup_addr);
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// +----------------------------------------------------------------------------
// | Module   : instr_fetch_unit
// | Purpose  : Instruction fetch FSM with PC, jump redirect and END halt.
// |            Define IFU_PREFETCH_EN to add a one-entry background prefetch.
// | Revision : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int         AW         = C_AW,
  parameter int         DW         = C_DW,
  parameter logic [7:0] END_OPCODE = C_OP_END
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req,
  input  logic          jump_en,
  input  logic [AW-1:0] jump_addr,
  output logic          imem_rd,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] ir,
  output logic          ir_valid,
  output logic [AW-1:0] pc,
  output logic          halt
);

  ifu_state_t    r_state;
  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_ir;
  logic          r_ir_valid;
  logic          r_halt;
  logic          r_imem_rd;
  logic [AW-1:0] r_imem_addr;

  logic          w_hit;
  logic [DW-1:0] w_pf_data;
  logic          w_pf_issue;

`ifdef IFU_PREFETCH_EN
  // 0: idle, 1: background read on the bus, 2: read data arrives this cycle
  logic [1:0] r_pf_phase;
  logic       w_buf_valid;
  logic       w_buf_fill;
  logic       w_buf_inval;
  logic       w_idle_hold;
  logic       w_pf_quiet;

  assign w_idle_hold = (r_state == S_IDLE) || (r_state == S_HOLD);
  assign w_pf_quiet  = (r_state == S_HOLD) && !fetch_req && !jump_en;
  assign w_pf_issue  = w_pf_quiet && !w_buf_valid && (r_pf_phase == 2'd0);
  assign w_buf_fill  = w_pf_quiet && (r_pf_phase == 2'd2);
  assign w_buf_inval = (r_state != S_HALT) &&
                       (jump_en || (fetch_req && w_hit && w_idle_hold));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pf_phase <= 2'd0;
    end else if (!w_pf_quiet) begin
      r_pf_phase <= 2'd0;
    end else begin
      case (r_pf_phase)
        2'd0:    r_pf_phase <= w_pf_issue ? 2'd1 : 2'd0;
        2'd1:    r_pf_phase <= 2'd2;
        default: r_pf_phase <= 2'd0;
      endcase
    end
  end

  ifu_prefetch_buf #(
    .AW (AW),
    .DW (DW)
  ) u_prefetch_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_fill        (w_buf_fill),
    .i_fill_tag    (r_pc),
    .i_fill_data   (imem_rdata),
    .i_inval       (w_buf_inval),
    .i_lookup_addr (r_pc),
    .o_valid       (w_buf_valid),
    .o_hit         (w_hit),
    .o_data        (w_pf_data)
  );
`else
  assign w_hit      = 1'b0;
  assign w_pf_data  = '0;
  assign w_pf_issue = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_ir        <= '0;
      r_ir_valid  <= 1'b0;
      r_halt      <= 1'b0;
      r_imem_rd   <= 1'b0;
      r_imem_addr <= '0;
    end else begin
      r_imem_rd <= 1'b0;
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (fetch_req && !jump_en && w_hit) begin
            r_ir       <= w_pf_data;
            r_ir_valid <= 1'b1;
            r_pc       <= r_pc + AW'(1);
            if (w_pf_data[7:0] == END_OPCODE) begin
              r_state <= S_HALT;
              r_halt  <= 1'b1;
            end else begin
              r_state <= S_HOLD;
            end
          end else if (fetch_req) begin
            // A simultaneous jump redirects first, so the fetch reads its target
            r_state     <= S_REQ;
            r_ir_valid  <= 1'b0;
            r_imem_rd   <= 1'b1;
            r_imem_addr <= jump_en ? jump_addr : r_pc;
            r_pc        <= jump_en ? jump_addr : r_pc;
          end else if (jump_en) begin
            r_pc <= jump_addr;
          end else if (w_pf_issue) begin
            r_imem_rd   <= 1'b1;
            r_imem_addr <= r_pc;
          end
        end
        S_REQ: begin
          if (jump_en) begin
            r_pc    <= jump_addr;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (jump_en) begin
            r_pc    <= jump_addr;
            r_state <= S_IDLE;
          end else begin
            r_ir       <= imem_rdata;
            r_ir_valid <= 1'b1;
            r_pc       <= r_pc + AW'(1);
            if (imem_rdata[7:0] == END_OPCODE) begin
              r_state <= S_HALT;
              r_halt  <= 1'b1;
            end else begin
              r_state <= S_HOLD;
            end
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_rd   = r_imem_rd;
  assign imem_addr = r_imem_addr;
  assign ir        = r_ir;
  assign ir_valid  = r_ir_valid;
  assign pc        = r_pc;
  assign halt      = r_halt;

endmodule

`default_nettype wire
